// File: rtl/riscv_mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   mdu_op_e    : RV32M/RV64M operation encodings as carried on the op port
//   mdu_state_e : sequencing states of the unit
package riscv_mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } mdu_state_e;

    // All divide/remainder encodings have the top op bit set.
    function automatic logic op_is_div(input mdu_op_e o);
        return o[2];
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration of the shared multiply/divide datapath.
//   acc      in  2*XLEN  working register
//                        multiply: {partial product high, remaining multiplier}
//                        divide  : {partial remainder, dividend/quotient bits}
//   operand  in  XLEN    multiplicand magnitude or divisor magnitude
//   is_div   in  1       select trial-subtract (1) or add-shift (0)
//   acc_next out 2*XLEN  register value after this iteration
module mdu_iter_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    input  logic              is_div,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] hi;
    logic [XLEN:0] diff;

    always_comb begin
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        // Remainder shifted left with the next dividend bit brought in.
        hi       = acc[2*XLEN-1:XLEN-1];
        diff     = hi - {1'b0, operand};
        acc_next = '0;
        if (!is_div) begin
            // Carry out of the add lands in the top bit as the register shifts right.
            acc_next = {sum, acc[XLEN-1:1]};
        end else if (diff[XLEN]) begin
            acc_next = {acc[2*XLEN-2:0], 1'b0};
        end else begin
            acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply-divide unit, one bit per cycle.
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   request handshake; in_ready only while idle
//   op, In1, In2        operation and rs1/rs2 operands, registered on accept
//   kill                abort any in-flight operation
//   out_valid/out_ready result handshake; result held until out_ready
//   Out                 result
//   Div_Zero, Overflow  divide-by-zero / signed overflow flags, valid with out_valid
module muldiv_unit
    import riscv_mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] In1,
    input  logic [XLEN-1:0] In2,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Out,
    output logic            Div_Zero,
    output logic            Overflow
);

    mdu_state_e        state_q, state_d;
    mdu_op_e           op_in, op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q, acc_next;
    logic [XLEN-1:0]   opa_q;
    logic              neg_q;
    logic [XLEN-1:0]   out_q;
    logic              dz_q, ovf_q;

    logic              in_s1, in_s2, in_neg;
    logic [XLEN-1:0]   mag1, mag2;
    logic              in_dz, in_ovf, in_special;
    logic [XLEN-1:0]   special_out;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_out;

    assign op_in = mdu_op_e'(op);

    // Operand decode for the accept cycle.
    always_comb begin
        in_s1 = ((op_in == MDU_MULH) || (op_in == MDU_MULHSU) ||
                 (op_in == MDU_DIV)  || (op_in == MDU_REM)) && In1[XLEN-1];
        in_s2 = ((op_in == MDU_MULH) || (op_in == MDU_DIV) ||
                 (op_in == MDU_REM)) && In2[XLEN-1];
        mag1  = in_s1 ? -In1 : In1;
        mag2  = in_s2 ? -In2 : In2;
        // Remainder follows the dividend sign; everything else the sign product.
        in_neg = (op_in == MDU_REM) ? in_s1 : (in_s1 ^ in_s2);
        in_dz  = op_is_div(op_in) && (In2 == '0);
        in_ovf = ((op_in == MDU_DIV) || (op_in == MDU_REM)) &&
                 (In1 == {1'b1, {(XLEN-1){1'b0}}}) && (In2 == '1);
        in_special  = in_dz || in_ovf;
        special_out = '0;
        if (in_dz) begin
            special_out = ((op_in == MDU_DIV) || (op_in == MDU_DIVU)) ? '1 : In1;
        end else if (op_in == MDU_DIV) begin
            special_out = In1;
        end
    end

    mdu_iter_step #(
        .XLEN(XLEN)
    ) u_step (
        .acc      (acc_q),
        .operand  (opa_q),
        .is_div   (op_is_div(op_q)),
        .acc_next (acc_next)
    );

    // Sign fix-up and result selection.
    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            MDU_MUL:                        fix_out = prod_fix[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_out = prod_fix[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:              fix_out = quo_fix;
            default:                        fix_out = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = in_special ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (kill) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= MDU_MUL;
            cnt_q <= '0;
            acc_q <= '0;
            opa_q <= '0;
            neg_q <= 1'b0;
            out_q <= '0;
            dz_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else if (kill) begin
            out_q <= '0;
            dz_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q  <= op_in;
                        cnt_q <= CNT_W'(XLEN);
                        neg_q <= in_neg;
                        // Multiplier/dividend seeds the low half; the other
                        // magnitude is the per-iteration addend/subtrahend.
                        if (op_is_div(op_in)) begin
                            acc_q <= {{XLEN{1'b0}}, mag1};
                            opa_q <= mag2;
                        end else begin
                            acc_q <= {{XLEN{1'b0}}, mag2};
                            opa_q <= mag1;
                        end
                        out_q <= special_out;
                        dz_q  <= in_dz;
                        ovf_q <= in_ovf && !in_dz;
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q - 1'b1;
                end
                ST_FIX: begin
                    out_q <= fix_out;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_q <= '0;
                        dz_q  <= 1'b0;
                        ovf_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign Out       = out_q;
    assign Div_Zero  = dz_q;
    assign Overflow  = ovf_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] In1 = '0;
    logic [31:0] In2 = '0;
    logic        kill = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] Out;
    logic        Div_Zero;
    logic        Overflow;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .In1       (In1),
        .In2       (In2),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (Out),
        .Div_Zero  (Div_Zero),
        .Overflow  (Overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: returns {Div_Zero, Overflow, Out} from plain 64-bit arithmetic.
    function automatic logic [33:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        longint unsigned up;
        logic [31:0] r;
        logic dz, ov;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        r = '0; dz = 1'b0; ov = 1'b0;
        case (f)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin up = ua * ub; r = up[63:32]; end
            3'd4: begin
                if (b == 0) begin r = 32'hFFFFFFFF; dz = 1'b1; end
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r = a; ov = 1'b1; end
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: begin
                if (b == 0) begin r = 32'hFFFFFFFF; dz = 1'b1; end
                else r = a / b;
            end
            3'd6: begin
                if (b == 0) begin r = a; dz = 1'b1; end
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r = 0; ov = 1'b1; end
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: begin
                if (b == 0) begin r = a; dz = 1'b1; end
                else r = a % b;
            end
        endcase
        return {dz, ov, r};
    endfunction

    // Scoreboard/compare process: inputs change at posedge+1, everything sampled at negedge.
    int          cyc = 0;
    int          acc_cyc = 0;
    logic        pending = 1'b0;
    logic        seen = 1'b0;
    logic        exp_special = 1'b0;
    logic [33:0] exp_v = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            pending = 1'b0;
        end else begin
            if (out_valid) begin
                if (!pending) begin
                    chk("spurious_out_valid", out_valid, 0);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        chk("latency", cyc - acc_cyc, exp_special ? 1 : 34);
                    end
                    chk("Out", Out, exp_v[31:0]);
                    chk("Div_Zero", Div_Zero, exp_v[33]);
                    chk("Overflow", Overflow, exp_v[32]);
                    chk("in_ready_while_done", in_ready, 0);
                    if (out_ready && !kill) pending = 1'b0;
                end
            end
            if (kill) pending = 1'b0;
            if (in_valid && in_ready && !kill) begin
                exp_v       = model(op, In1, In2);
                exp_special = exp_v[33] | exp_v[32];
                pending     = 1'b1;
                seen        = 1'b0;
                acc_cyc     = cyc;
            end
        end
    end

    logic [31:0] last_out;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (!out_valid && t < 60) begin
            step();
            t++;
        end
        if (!out_valid) chk("wait_out_valid", out_valid, 1);
        last_out = Out;
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input int kill_at);
        in_valid = 1'b1; op = f; In1 = a; In2 = b; out_ready = 1'b0;
        step();
        in_valid = 1'b0; op = 3'($urandom); In1 = $urandom; In2 = $urandom;
        if (kill_at > 0) begin
            repeat (kill_at - 1) step();
            kill = 1'b1;
            step();
            kill = 1'b0;
            chk("in_ready_after_kill", in_ready, 1);
            chk("out_valid_after_kill", out_valid, 0);
            return;
        end
        wait_valid();
        repeat (hold) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("in_ready_after_done", in_ready, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [33:0] m;
        logic [2:0]  f;
        logic [31:0] a, b;
        int          r, hold, kat;

        // Model pins
        m = model(3'd0, 32'd7, 32'hFFFFFFFD);       chk("model_mul", m, {2'b00, 32'hFFFFFFEB});
        m = model(3'd1, 32'h80000000, 32'h80000000); chk("model_mulh", m, {2'b00, 32'h40000000});
        m = model(3'd2, 32'hFFFFFFFF, 32'd2);       chk("model_mulhsu", m, {2'b00, 32'hFFFFFFFF});
        m = model(3'd6, 32'hFFFFFFF9, 32'd2);       chk("model_rem", m, {2'b00, 32'hFFFFFFFF});
        m = model(3'd4, 32'h80000000, 32'hFFFFFFFF); chk("model_div_ovf", m, {2'b01, 32'h80000000});
        m = model(3'd6, 32'd5, 32'd0);              chk("model_rem_dz", m, {2'b10, 32'd5});

        // Reset state
        repeat (3) step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_Out", Out, 0);
        chk("rst_Div_Zero", Div_Zero, 0);
        chk("rst_Overflow", Overflow, 0);
        rst = 1'b0;
        step();

        // Directed cases with literal expectations
        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 0, 0);         chk("mul_7_m3", last_out, 32'hFFFFFFEB);
        run_op(3'd1, 32'h80000000, 32'h80000000, 0, 0);  chk("mulh_min", last_out, 32'h40000000);
        run_op(3'd3, 32'h80000000, 32'h80000000, 0, 0);  chk("mulhu_min", last_out, 32'h40000000);
        run_op(3'd2, 32'hFFFFFFFF, 32'd2, 0, 0);         chk("mulhsu", last_out, 32'hFFFFFFFF);
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 0, 0);         chk("div_m7_2", last_out, 32'hFFFFFFFD);
        run_op(3'd6, 32'hFFFFFFF9, 32'd2, 0, 0);         chk("rem_m7_2", last_out, 32'hFFFFFFFF);
        run_op(3'd5, 32'd5, 32'd0, 0, 0);                chk("divu_dz", last_out, 32'hFFFFFFFF);
        run_op(3'd6, 32'd5, 32'd0, 0, 0);                chk("rem_dz", last_out, 32'd5);
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 0, 0);  chk("div_ovf", last_out, 32'h80000000);
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 0, 0);  chk("rem_ovf", last_out, 32'd0);

        // Held result, then a request presented on the release cycle
        run_op(3'd5, 32'd100, 32'd7, 5, 0);              chk("divu_hold", last_out, 32'd14);
        in_valid = 1'b1; op = 3'd5; In1 = 32'd100; In2 = 32'd7;
        step();
        in_valid = 1'b0;
        wait_valid();
        chk("divu_100_7", last_out, 32'd14);
        out_ready = 1'b1; in_valid = 1'b1; op = 3'd7;
        step();
        out_ready = 1'b0;
        chk("idle_after_release", in_ready, 1);
        step();
        in_valid = 1'b0;
        wait_valid();
        chk("remu_100_7", last_out, 32'd2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // kill, then rst, at CALC cycle 10
        run_op(3'd0, 32'h12345, 32'h6789, 0, 10);
        repeat (40) step();
        in_valid = 1'b1; op = 3'd0; In1 = 32'h12345; In2 = 32'h6789;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_Out", Out, 0);
        rst = 1'b0;
        repeat (40) step();
        run_op(3'd0, 32'd3, 32'd4, 0, 0);                chk("mul_3_4", last_out, 32'd12);

        // Randomized traffic against the model
        for (int i = 0; i < 200; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            r = $urandom_range(0, 9);
            if (r == 0) b = 32'd0;
            if (r == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            if (r == 2) begin a = $urandom_range(0, 100); b = $urandom_range(0, 20); end
            if (r == 3) a = 32'h80000000;
            hold = $urandom_range(0, 3);
            kat  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 40) : 0;
            run_op(f, a, b, hold, kat);
        end

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
